game_cursor_draw: RTL and testbench

//  VGA overlay stage directly downstream of the game board grid stage. Holds the player's

---
 rtl/game_cursor_draw.sv | 184 ++++++++++++++++++
 tb/tb_game_cursor_draw.sv | 271 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/game_cursor_draw.sv
// game_cursor_draw: keeps the selected board cell and draws a 2-px outline around it on the VGA bus.
// The optional blink FSM is compiled in when GAME_CURSOR_BLINK_EN is defined.
package game_cursor_draw_pkg;
  localparam int unsigned HCNT_W = 11;
  localparam int unsigned VCNT_W = 11;
  localparam int unsigned RGB_W  = 12;

  typedef struct packed {
    logic [HCNT_W-1:0] hcount;
    logic [VCNT_W-1:0] vcount;
    logic              hsync;
    logic              vsync;
    logic              hblnk;
    logic              vblnk;
    logic [RGB_W-1:0]  rgb;
  } vga_bus_t;
endpackage

module game_cursor_draw
  import game_cursor_draw_pkg::*;
#(
  parameter logic [11:0] CURSOR_COLOR = 12'hF00,
  parameter int unsigned BLINK_FRAMES = 30,
  parameter int unsigned CELL_PX      = 16
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       is_game_on,
  input  logic [2:0] board_size,
  input  logic       move_up,
  input  logic       move_down,
  input  logic       move_left,
  input  logic       move_right,
  input  vga_bus_t   bus_in,
  output vga_bus_t   bus_out,
  output logic [3:0] cursor_row,
  output logic [3:0] cursor_col
);
  localparam int unsigned GEO_W = 16;
  localparam int unsigned POS_W = 4;
  localparam logic [GEO_W-1:0] H_RES = 16'd1024;
  localparam logic [GEO_W-1:0] V_RES = 16'd768;
  localparam logic [GEO_W-1:0] CELL  = GEO_W'(CELL_PX);
  localparam logic [GEO_W-1:0] EDGE  = 16'd2;

  logic [2:0]       board_q;
  logic [POS_W-1:0] cursor_row_q, cursor_row_d;
  logic [POS_W-1:0] cursor_col_q, cursor_col_d;
  vga_bus_t         bus_q, bus_d;

  logic             board_legal;
  logic [GEO_W-1:0] n_cells, board_px, x0, y0, hx, vy;
  logic [GEO_W-1:0] h_pix, v_pix, h_off, v_off;
  logic             in_box, on_edge, outline, draw_en, visible;
  logic [POS_W-1:0] n_last;
  logic             board_chg, row_mv, col_mv, move_applied;

  // Cursor box geometry for the current board, centred on the 1024x768 screen.
  always_comb begin
    board_legal = (board_size >= 3'd1) && (board_size <= 3'd4);
    n_cells     = GEO_W'(board_size) * GEO_W'(board_size);
    board_px    = CELL * n_cells;
    x0          = (H_RES - board_px) >> 1;
    y0          = (V_RES - board_px) >> 1;
    hx          = x0 + GEO_W'(cursor_col_q) * CELL;
    vy          = y0 + GEO_W'(cursor_row_q) * CELL;
    h_pix       = GEO_W'(bus_in.hcount);
    v_pix       = GEO_W'(bus_in.vcount);
    h_off       = h_pix - hx;
    v_off       = v_pix - vy;
    in_box      = (h_pix >= hx) && (h_pix < hx + CELL) &&
                  (v_pix >= vy) && (v_pix < vy + CELL);
    on_edge     = (h_off < EDGE) || (h_off >= CELL - EDGE) ||
                  (v_off < EDGE) || (v_off >= CELL - EDGE);
    outline     = in_box && on_edge;
  end

  // Cursor next state: board change / illegal size win over moves; opposite moves cancel.
  always_comb begin
    board_chg    = (board_q != board_size);
    row_mv       = move_up ^ move_down;
    col_mv       = move_left ^ move_right;
    move_applied = is_game_on && board_legal && !board_chg && (row_mv || col_mv);
    n_last       = POS_W'(n_cells - 16'd1);
    cursor_row_d = cursor_row_q;
    cursor_col_d = cursor_col_q;
    if (!board_legal || board_chg) begin
      cursor_row_d = '0;
      cursor_col_d = '0;
    end else if (is_game_on) begin
      if (row_mv) begin
        if (move_up) begin
          cursor_row_d = (cursor_row_q == '0) ? n_last : cursor_row_q - POS_W'(1);
        end else begin
          cursor_row_d = (cursor_row_q >= n_last) ? '0 : cursor_row_q + POS_W'(1);
        end
      end
      if (col_mv) begin
        if (move_left) begin
          cursor_col_d = (cursor_col_q == '0) ? n_last : cursor_col_q - POS_W'(1);
        end else begin
          cursor_col_d = (cursor_col_q >= n_last) ? '0 : cursor_col_q + POS_W'(1);
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      board_q      <= '0;
      cursor_row_q <= '0;
      cursor_col_q <= '0;
    end else begin
      board_q      <= board_size;
      cursor_row_q <= cursor_row_d;
      cursor_col_q <= cursor_col_d;
    end
  end

`ifdef GAME_CURSOR_BLINK_EN
  localparam int unsigned CNT_W = 8;
  localparam logic [0:0]  SHOW  = 1'b0;
  localparam logic [0:0]  HIDE  = 1'b1;

  logic [0:0]       state_q, state_d;
  logic [CNT_W-1:0] blink_cnt_q, blink_cnt_d;
  logic             frame_tick;

  // bus_q.vsync is the previous bus_in.vsync, so it doubles as the edge detector.
  always_comb begin
    state_d     = state_q;
    blink_cnt_d = blink_cnt_q;
    frame_tick  = bus_in.vsync && !bus_q.vsync;
    if (!is_game_on || move_applied) begin
      state_d     = SHOW;
      blink_cnt_d = '0;
    end else if (frame_tick) begin
      if (blink_cnt_q >= CNT_W'(BLINK_FRAMES - 1)) begin
        blink_cnt_d = '0;
        state_d     = (state_q == SHOW) ? HIDE : SHOW;
      end else begin
        blink_cnt_d = blink_cnt_q + CNT_W'(1);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= SHOW;
      blink_cnt_q <= '0;
    end else begin
      state_q     <= state_d;
      blink_cnt_q <= blink_cnt_d;
    end
  end

  assign visible = (state_q == SHOW);
`else
  logic unused_blink_cfg;
  assign unused_blink_cfg = ^BLINK_FRAMES;
  assign visible          = 1'b1;
`endif

  // Pixel path: everything passes through one register, outline pixels recoloured.
  always_comb begin
    draw_en = is_game_on && visible && board_legal;
    bus_d   = bus_in;
    if (draw_en && outline && !bus_in.hblnk && !bus_in.vblnk) begin
      bus_d.rgb = CURSOR_COLOR;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      bus_q <= '0;
    end else begin
      bus_q <= bus_d;
    end
  end

  assign bus_out    = bus_q;
  assign cursor_row = cursor_row_q;
  assign cursor_col = cursor_col_q;
endmodule

// File: tb/tb_game_cursor_draw.sv
// Bench for game_cursor_draw: vector table, directed corner sequences and a randomized run
// against a frame-count based reference model.
module tb_game_cursor_draw;
  import game_cursor_draw_pkg::*;

  localparam int unsigned BF = 2;
  localparam logic [11:0] CC = 12'hF00;
`ifdef GAME_CURSOR_BLINK_EN
  localparam bit BLINK = 1'b1;
`else
  localparam bit BLINK = 1'b0;
`endif

  logic       clk = 1'b0;
  logic       rst;
  logic       is_game_on;
  logic [2:0] board_size;
  logic       move_up, move_down, move_left, move_right;
  vga_bus_t   bus_in, bus_out;
  logic [3:0] cursor_row, cursor_col;

  int checks   = 0;
  int failures = 0;

  // Reference model state
  int       m_row, m_col, m_bs_prev, m_ticks;
  logic     m_vs_prev;
  vga_bus_t m_bus;

  game_cursor_draw #(.CURSOR_COLOR(CC), .BLINK_FRAMES(BF), .CELL_PX(16)) dut (
    .clk(clk), .rst(rst), .is_game_on(is_game_on), .board_size(board_size),
    .move_up(move_up), .move_down(move_down), .move_left(move_left), .move_right(move_right),
    .bus_in(bus_in), .bus_out(bus_out), .cursor_row(cursor_row), .cursor_col(cursor_col)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  function automatic bit is_outline(int bs, int row, int col, int h, int v);
    int n, x0, y0, hx, vy, ox, oy;
    n  = bs * bs;
    x0 = (1024 - 16 * n) / 2;
    y0 = (768 - 16 * n) / 2;
    hx = x0 + col * 16;
    vy = y0 + row * 16;
    if (h < hx || h >= hx + 16 || v < vy || v >= vy + 16) return 1'b0;
    ox = h - hx;
    oy = v - vy;
    return (ox < 2) || (ox > 13) || (oy < 2) || (oy > 13);
  endfunction

  // One clock: advance the model with the inputs seen at the edge, then compare.
  task automatic step();
    bit vis, legal, chg, applied, tick;
    int n, bs;
    @(posedge clk);
    bs    = int'(board_size);
    legal = (bs >= 1) && (bs <= 4);
    vis   = BLINK ? (((m_ticks / int'(BF)) % 2) == 0) : 1'b1;
    if (rst) begin
      m_bus = '0; m_row = 0; m_col = 0; m_bs_prev = 0; m_ticks = 0; m_vs_prev = 1'b0;
    end else begin
      m_bus = bus_in;
      if (is_game_on && vis && legal && !bus_in.hblnk && !bus_in.vblnk &&
          is_outline(bs, m_row, m_col, int'(bus_in.hcount), int'(bus_in.vcount)))
        m_bus.rgb = CC;
      n       = bs * bs;
      chg     = (bs != m_bs_prev);
      tick    = bus_in.vsync && !m_vs_prev;
      applied = is_game_on && legal && !chg &&
                ((move_up != move_down) || (move_left != move_right));
      if (!legal || chg) begin
        m_row = 0; m_col = 0;
      end else if (applied) begin
        if (move_up && !move_down) m_row = (m_row + n - 1) % n;
        if (move_down && !move_up) m_row = (m_row + 1) % n;
        if (move_left && !move_right) m_col = (m_col + n - 1) % n;
        if (move_right && !move_left) m_col = (m_col + 1) % n;
      end
      if (!is_game_on || applied) m_ticks = 0;
      else if (tick) m_ticks++;
      m_bs_prev = bs;
      m_vs_prev = bus_in.vsync;
    end
    #1;
    chk("model_bus", 64'(bus_out), 64'(m_bus));
    chk("model_row", 64'(cursor_row), 64'(m_row));
    chk("model_col", 64'(cursor_col), 64'(m_col));
  endtask

  task automatic set_pix(input int h, input int v, input logic [11:0] rgb);
    bus_in.hcount = 11'(h);
    bus_in.vcount = 11'(v);
    bus_in.hblnk  = 1'b0;
    bus_in.vblnk  = 1'b0;
    bus_in.rgb    = rgb;
  endtask

  task automatic pulse(input logic u, input logic d, input logic l, input logic r);
    move_up = u; move_down = d; move_left = l; move_right = r;
    step();
    move_up = 1'b0; move_down = 1'b0; move_left = 1'b0; move_right = 1'b0;
  endtask

  task automatic vs_edge();
    bus_in.vsync = 1'b1;
    step();
    bus_in.vsync = 1'b0;
    step();
  endtask

  typedef struct {
    string       name;
    int          h;
    int          v;
    logic        hb;
    logic        vb;
    logic [11:0] rgb;
    logic [11:0] exp;
  } pix_vec_t;

  pix_vec_t vecs[11];

  initial begin
    vecs[0]  = '{"corner_440_312",    440, 312, 1'b0, 1'b0, 12'h123, CC};
    vecs[1]  = '{"inner_441_313",     441, 313, 1'b0, 1'b0, 12'h234, CC};
    vecs[2]  = '{"interior_444_316",  444, 316, 1'b0, 1'b0, 12'h345, 12'h345};
    vecs[3]  = '{"right_edge_454",    454, 316, 1'b0, 1'b0, 12'h456, CC};
    vecs[4]  = '{"right_edge_455",    455, 320, 1'b0, 1'b0, 12'h567, CC};
    vecs[5]  = '{"outside_456",       456, 312, 1'b0, 1'b0, 12'h678, 12'h678};
    vecs[6]  = '{"outside_439",       439, 312, 1'b0, 1'b0, 12'h789, 12'h789};
    vecs[7]  = '{"bottom_edge_326",   444, 326, 1'b0, 1'b0, 12'h89A, CC};
    vecs[8]  = '{"below_box_328",     444, 328, 1'b0, 1'b0, 12'h9AB, 12'h9AB};
    vecs[9]  = '{"hblank_corner",     440, 312, 1'b1, 1'b0, 12'hABC, 12'hABC};
    vecs[10] = '{"vblank_corner",     441, 313, 1'b0, 1'b1, 12'hBCD, 12'hBCD};

    m_row = 0; m_col = 0; m_bs_prev = 0; m_ticks = 0; m_vs_prev = 1'b0; m_bus = '0;
    rst = 1'b1; is_game_on = 1'b1; board_size = 3'd3;
    move_up = 1'b0; move_down = 1'b0; move_left = 1'b0; move_right = 1'b0;
    bus_in = '{hcount: 11'd500, vcount: 11'd400, hsync: 1'b1, vsync: 1'b0,
               hblnk: 1'b1, vblnk: 1'b1, rgb: 12'hFFF};

    // Reset holds everything at zero
    step();
    step();
    chk("reset_bus", 64'(bus_out), 64'd0);
    chk("reset_row", 64'(cursor_row), 64'd0);
    chk("reset_col", 64'(cursor_col), 64'd0);
    rst = 1'b0;
    set_pix(100, 100, 12'h5A5);
    step();
    chk("pass_pix0", 64'(bus_out.rgb), 64'h5A5);
    chk("pass_hcount", 64'(bus_out.hcount), 64'd100);
    set_pix(101, 100, 12'h3C3);
    step();
    chk("pass_pix1", 64'(bus_out.rgb), 64'h3C3);

    // Outline geometry table, board 3, cursor (0,0)
    for (int i = 0; i < 11; i++) begin
      set_pix(vecs[i].h, vecs[i].v, vecs[i].rgb);
      bus_in.hblnk = vecs[i].hb;
      bus_in.vblnk = vecs[i].vb;
      step();
      chk(vecs[i].name, 64'(bus_out.rgb), 64'(vecs[i].exp));
    end
    set_pix(300, 200, 12'h111);

    // Wrap-around moves
    pulse(1'b0, 1'b0, 1'b1, 1'b0);
    chk("left_wrap_row", 64'(cursor_row), 64'd0);
    chk("left_wrap_col", 64'(cursor_col), 64'd8);
    pulse(1'b1, 1'b0, 1'b0, 1'b0);
    chk("up_wrap_row", 64'(cursor_row), 64'd8);
    for (int i = 0; i < 9; i++) pulse(1'b0, 1'b0, 1'b0, 1'b1);
    chk("nine_right_col", 64'(cursor_col), 64'd8);

    // Walk to (2,2), then cancelled vertical pair with a column move
    pulse(1'b0, 1'b1, 1'b0, 1'b0);
    pulse(1'b0, 1'b1, 1'b0, 1'b0);
    pulse(1'b0, 1'b1, 1'b0, 1'b0);
    for (int i = 0; i < 3; i++) pulse(1'b0, 1'b0, 1'b0, 1'b1);
    chk("walk_row", 64'(cursor_row), 64'd2);
    chk("walk_col", 64'(cursor_col), 64'd2);
    pulse(1'b1, 1'b1, 1'b0, 1'b1);
    chk("cancel_row", 64'(cursor_row), 64'd2);
    chk("cancel_col", 64'(cursor_col), 64'd3);
    pulse(1'b0, 1'b0, 1'b1, 1'b1);
    chk("cancel_lr_col", 64'(cursor_col), 64'd3);
    board_size = 3'd2;
    pulse(1'b0, 1'b0, 1'b0, 1'b1);
    chk("board_chg_row", 64'(cursor_row), 64'd0);
    chk("board_chg_col", 64'(cursor_col), 64'd0);

    // Blink behaviour on board 3, cursor (0,0)
    board_size = 3'd3;
    step();
    set_pix(440, 312, 12'h0A0);
    vs_edge();
    vs_edge();
    chk("blink_hidden", 64'(bus_out.rgb), BLINK ? 64'h0A0 : 64'(CC));
    vs_edge();
    vs_edge();
    chk("blink_shown", 64'(bus_out.rgb), 64'(CC));
    vs_edge();
    vs_edge();
    chk("blink_hidden2", 64'(bus_out.rgb), BLINK ? 64'h0A0 : 64'(CC));
    pulse(1'b0, 1'b1, 1'b0, 1'b0);
    set_pix(440, 328, 12'h0A0);
    step();
    chk("move_unhides", 64'(bus_out.rgb), 64'(CC));

    // Game off: moves ignored, nothing drawn
    is_game_on = 1'b0;
    pulse(1'b1, 1'b0, 1'b1, 1'b0);
    chk("off_row_held", 64'(cursor_row), 64'd1);
    chk("off_col_held", 64'(cursor_col), 64'd0);
    step();
    chk("off_no_draw", 64'(bus_out.rgb), 64'h0A0);

    // Illegal board size: nothing drawn, cursor parked
    is_game_on = 1'b1;
    board_size = 3'd0;
    step();
    set_pix(512, 384, 12'h00F);
    step();
    chk("bs0_no_draw", 64'(bus_out.rgb), 64'h00F);
    pulse(1'b0, 1'b1, 1'b0, 1'b1);
    chk("bs0_row", 64'(cursor_row), 64'd0);
    chk("bs0_col", 64'(cursor_col), 64'd0);

    // Randomized run against the model
    board_size = 3'd3;
    for (int c = 0; c < 3000; c++) begin
      int bs, n, hx, vy;
      rst        = ($urandom_range(0, 499) == 0);
      is_game_on = ($urandom_range(0, 15) != 0);
      if ($urandom_range(0, 63) == 0) board_size = 3'($urandom_range(0, 5));
      move_up    = ($urandom_range(0, 5) == 0);
      move_down  = ($urandom_range(0, 5) == 0);
      move_left  = ($urandom_range(0, 5) == 0);
      move_right = ($urandom_range(0, 5) == 0);
      if ($urandom_range(0, 7) == 0) bus_in.vsync = ~bus_in.vsync;
      bus_in.hsync = 1'($urandom_range(0, 1));
      bus_in.hblnk = ($urandom_range(0, 7) == 0);
      bus_in.vblnk = ($urandom_range(0, 7) == 0);
      bus_in.rgb   = 12'($urandom_range(0, 4095));
      bs = int'(board_size);
      n  = bs * bs;
      if (bs >= 1 && bs <= 4 && $urandom_range(0, 3) != 0) begin
        hx = (1024 - 16 * n) / 2 + m_col * 16;
        vy = (768 - 16 * n) / 2 + m_row * 16;
        bus_in.hcount = 11'(hx + int'($urandom_range(0, 19)) - 2);
        bus_in.vcount = 11'(vy + int'($urandom_range(0, 19)) - 2);
      end else begin
        bus_in.hcount = 11'($urandom_range(0, 1023));
        bus_in.vcount = 11'($urandom_range(0, 767));
      end
      step();
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
